// File: rtl/intersection_phase_scheduler_pkg.sv
// intersection_phase_scheduler_pkg: phase states, lamp codes and BCD helpers
package intersection_phase_scheduler_pkg;
  typedef enum logic [2:0] {
    NS_GREEN, NS_YELLOW, RED_TO_EW, EW_GREEN, EW_YELLOW, RED_TO_NS
  } phase_e;
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  typedef logic [3:0] bcd_t;
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
endpackage

// File: rtl/intersection_phase_scheduler_bcd_down_counter.sv
// bcd_down_counter: two-digit BCD down counter with load and is-one flag
module bcd_down_counter
  import intersection_phase_scheduler_pkg::*;
#(
  parameter logic [7:0] RST_VAL = 8'h19
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       is_one
);
  bcd_t tens_q, tens_d, ones_q, ones_d;
  // load wins over decrement; ones borrow from tens
  always_comb begin
    tens_d = load ? load_val[7:4] : (dec && ones_q == 4'd0) ? tens_q - 4'd1 : tens_q;
    ones_d = load ? load_val[3:0] : !dec ? ones_q : (ones_q == 4'd0) ? 4'd9 : ones_q - 4'd1;
  end
  // digit registers
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      tens_q <= RST_VAL[7:4];
      ones_q <= RST_VAL[3:0];
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end
  assign tens   = tens_q;
  assign ones   = ones_q;
  assign is_one = tens_q == 4'd0 && ones_q == 4'd1;
endmodule

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler: demand-actuated two-road signal phase controller
module intersection_phase_scheduler
  import intersection_phase_scheduler_pkg::*;
#(
  parameter int TICK_DIV  = 50,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 19,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 1,
  parameter int PED_WALK  = 7
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       req_ns,
  input  logic       req_ew,
  input  logic       ped_ns_btn,
  input  logic       ped_ew_btn,
  output logic [2:0] lamp_ns,
  output logic [2:0] lamp_ew,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       direction,
  output logic       tick
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [7:0] MAX_B = to_bcd(MAX_GREEN);
  localparam logic [7:0] YEL_B = to_bcd(YELLOW);
  localparam logic [7:0] RED_B = to_bcd(ALL_RED);
  phase_e state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0] el_q, el_d, el_nx, load_val;
  logic tick_q, walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
  logic ped_ns_q, ped_ns_d, ped_ew_q, ped_ew_d;
  logic green, own, opp, is_one, go_yel, enter_ns, enter_ew, load;
  assign pre_d    = (pre_q == PW'(TICK_DIV - 1)) ? '0 : pre_q + PW'(1);
  assign green    = state_q == NS_GREEN || state_q == EW_GREEN;
  assign own      = (state_q == NS_GREEN) ? (req_ns | walk_ns_q) : (req_ew | walk_ew_q);
  assign opp      = (state_q == NS_GREEN) ? (req_ew | ped_ew_q) : (req_ns | ped_ns_q);
  assign el_nx    = el_q + 8'd1;
  assign go_yel   = green & opp & (is_one | (el_nx >= 8'(MIN_GREEN) & !own));
  assign enter_ns = tick_q & is_one & state_q == RED_TO_NS;
  assign enter_ew = tick_q & is_one & state_q == RED_TO_EW;
  assign load     = tick_q & (state_d != state_q | (green & is_one));
  assign load_val = (state_d == NS_GREEN || state_d == EW_GREEN) ? MAX_B :
                    (state_d == NS_YELLOW || state_d == EW_YELLOW) ? YEL_B : RED_B;
  assign el_d      = !tick_q ? el_q : load ? 8'd0 : el_nx;
  assign walk_ns_d = enter_ns ? (ped_ns_q | ped_ns_btn) :
                     (tick_q && el_nx >= 8'(PED_WALK)) ? 1'b0 : walk_ns_q;
  assign walk_ew_d = enter_ew ? (ped_ew_q | ped_ew_btn) :
                     (tick_q && el_nx >= 8'(PED_WALK)) ? 1'b0 : walk_ew_q;
  assign ped_ns_d  = enter_ns ? 1'b0 : (ped_ns_btn & !walk_ns_q) ? 1'b1 : ped_ns_q;
  assign ped_ew_d  = enter_ew ? 1'b0 : (ped_ew_btn & !walk_ew_q) ? 1'b1 : ped_ew_q;
  // phase state register
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= NS_GREEN;
    else        state_q <= state_d;
  end
  // advance around the ring on a tick: green on gap/max-out, others when their count expires
  always_comb begin
    state_d = state_q;
    if (tick_q && (go_yel || (!green && is_one)))
      state_d = (state_q == RED_TO_NS) ? NS_GREEN : phase_e'(state_q + 3'd1);
  end
  // lamps and direction decoded from the registered phase
  always_comb begin
    lamp_ns   = (state_q == NS_GREEN) ? LAMP_GRN : (state_q == NS_YELLOW) ? LAMP_YEL : LAMP_RED;
    lamp_ew   = (state_q == EW_GREEN) ? LAMP_GRN : (state_q == EW_YELLOW) ? LAMP_YEL : LAMP_RED;
    direction = state_q inside {NS_GREEN, NS_YELLOW, RED_TO_EW};
  end
  // prescaler, tick, elapsed green time, walk lamps and ped latches
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pre_q     <= '0;
      tick_q    <= 1'b0;
      el_q      <= 8'd0;
      walk_ns_q <= 1'b0;
      walk_ew_q <= 1'b0;
      ped_ns_q  <= 1'b0;
      ped_ew_q  <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      tick_q    <= pre_d == PW'(TICK_DIV - 1);
      el_q      <= el_d;
      walk_ns_q <= walk_ns_d;
      walk_ew_q <= walk_ew_d;
      ped_ns_q  <= ped_ns_d;
      ped_ew_q  <= ped_ew_d;
    end
  end
  bcd_down_counter #(.RST_VAL(MAX_B)) u_cnt (
    .CLK      (CLK),
    .Reset    (Reset),
    .load     (load),
    .load_val (load_val),
    .dec      (tick_q & !load),
    .tens     (cnt_tens),
    .ones     (cnt_ones),
    .is_one   (is_one)
  );
  assign walk_ns = walk_ns_q;
  assign walk_ew = walk_ew_q;
  assign tick    = tick_q;
endmodule
